// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer <-> datapath/memory bundle: fetch and data handshakes, decoder flags, strobes, status.
// master = sequencer side, slave = datapath/memory side.
interface cpu_seq_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             imem_req;
   logic             imem_ack;
   logic             ir_we;
   logic             is_load;
   logic             is_store;
   logic             is_halt;
   logic             reg_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   logic             rf_we;
   logic             pc_we;
   logic [2:0]       stage;
   logic             halted;
   logic [CNT_W-1:0] retired;

   modport master (
      output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, stage, halted, retired,
      input  imem_ack, is_load, is_store, is_halt, reg_we, dmem_ack
   );

   modport slave (
      input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, stage, halted, retired,
      output imem_ack, is_load, is_store, is_halt, reg_we, dmem_ack
   );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; 4 cycles ALU, 5 cycles load/store, +1 per withheld ack.
// Requests are level-held until ack (no backpressure beyond that); HALT is sticky until rst.
module cpu_seq_ctrl #(
   parameter logic [2:0] RESET_STAGE = 3'd0,
   parameter int         CNT_W       = 32
) (
   input  logic           clk,
   input  logic           rst,
   cpu_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t           state_q;
   logic             load_q;
   logic             store_q;
   logic             reg_we_q;
   logic             imem_req_q;
   logic             dmem_req_q;
   logic             dmem_we_q;
   logic             rf_we_q;
   logic             pc_we_q;
   logic             halted_q;
   logic [CNT_W-1:0] retired_q;

   // Strobes are registered alongside the state transition that enables them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= state_t'(RESET_STAGE);
         load_q     <= 1'b0;
         store_q    <= 1'b0;
         reg_we_q   <= 1'b0;
         imem_req_q <= 1'b1;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         pc_we_q    <= 1'b0;
         halted_q   <= 1'b0;
         retired_q  <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (bus.imem_ack) begin
                  state_q    <= DECODE;
                  imem_req_q <= 1'b0;
               end
            end
            DECODE: begin
               // Load wins when the decoder flags both load and store.
               load_q   <= bus.is_load;
               store_q  <= bus.is_store & ~bus.is_load;
               reg_we_q <= bus.reg_we;
               if (bus.is_halt) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (load_q || store_q) begin
                  state_q    <= MEM;
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= store_q;
               end else begin
                  state_q <= WB;
                  rf_we_q <= reg_we_q;
                  pc_we_q <= 1'b1;
               end
            end
            MEM: begin
               if (bus.dmem_ack) begin
                  state_q    <= WB;
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  rf_we_q    <= reg_we_q;
                  pc_we_q    <= 1'b1;
               end
            end
            WB: begin
               state_q    <= FETCH;
               rf_we_q    <= 1'b0;
               pc_we_q    <= 1'b0;
               imem_req_q <= 1'b1;
               retired_q  <= retired_q + 1'b1;
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q    <= FETCH;
               imem_req_q <= 1'b1;
               dmem_req_q <= 1'b0;
               dmem_we_q  <= 1'b0;
               rf_we_q    <= 1'b0;
               pc_we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req = imem_req_q;
   assign bus.ir_we    = imem_req_q & bus.imem_ack;
   assign bus.dmem_req = dmem_req_q;
   assign bus.dmem_we  = dmem_we_q;
   assign bus.rf_we    = rf_we_q;
   assign bus.pc_we    = pc_we_q;
   assign bus.stage    = state_q;
   assign bus.halted   = halted_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: cycle table for ALU/load/store/halt traffic plus hand sequences
// for sticky halt, reset during MEM and counter wrap on a 4-bit instance.
module tb_cpu_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cpu_seq_ctrl_if #(.CNT_W(32)) bus  ();
   cpu_seq_ctrl_if #(.CNT_W(4))  bus2 ();

   cpu_seq_ctrl #(.RESET_STAGE(3'd0), .CNT_W(32)) dut  (.clk(clk), .rst(rst),  .bus(bus));
   cpu_seq_ctrl #(.RESET_STAGE(3'd0), .CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

   typedef struct {
      logic       ia, da, ld, st, ht, rw;
      logic [2:0] stg;
      logic       ireq, irwe, dreq, dwe, rfwe, pcwe, hlt;
      int         ret;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic ia, da, ld, st, ht, rw, input int stg,
                      input logic ireq, irwe, dreq, dwe, rfwe, pcwe, hlt, input int ret);
      vec_t v;
      v.ia = ia; v.da = da; v.ld = ld; v.st = st; v.ht = ht; v.rw = rw;
      v.stg = 3'(stg);
      v.ireq = ireq; v.irwe = irwe; v.dreq = dreq; v.dwe = dwe;
      v.rfwe = rfwe; v.pcwe = pcwe; v.hlt = hlt; v.ret = ret;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ia, da, ld, st, ht, rw);
      bus.imem_ack = ia; bus.dmem_ack = da;
      bus.is_load = ld; bus.is_store = st; bus.is_halt = ht; bus.reg_we = rw;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      bus2.imem_ack = 1'b1; bus2.dmem_ack = 1'b0;
      bus2.is_load = 1'b0; bus2.is_store = 1'b0; bus2.is_halt = 1'b0; bus2.reg_we = 1'b0;

      //   ia da ld st ht rw  stg ireq irwe dreq dwe rfwe pcwe hlt ret
      add(1, 0, 0, 0, 0, 1,  0,  1, 1, 0, 0, 0, 0, 0, 0);  // ALU, immediate fetch
      add(0, 0, 0, 0, 0, 1,  1,  0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,  4,  0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0, 1);  // load, 2 fetch waits
      add(0, 0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 1,  1,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 1);  // 3 data waits
      add(0, 0, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,  4,  0, 0, 0, 0, 1, 1, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 0, 2);  // store, reg_we=0
      add(0, 0, 0, 1, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 0, 0, 2);
      add(0, 1, 0, 0, 0, 0,  3,  0, 0, 1, 1, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 0,  4,  0, 0, 0, 0, 0, 1, 0, 2);
      add(1, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 0, 3);  // load+store flags -> load
      add(0, 0, 1, 1, 0, 1,  1,  0, 0, 0, 0, 0, 0, 0, 3);
      add(0, 1, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 0, 0, 3);
      add(1, 0, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 3);  // stray imem_ack in MEM
      add(0, 1, 0, 0, 0, 0,  3,  0, 0, 1, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 0,  4,  0, 0, 0, 0, 1, 1, 0, 3);
      add(1, 1, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 0, 4);  // halt, stray dmem_ack
      add(1, 1, 0, 0, 1, 0,  1,  0, 0, 0, 0, 0, 0, 0, 4);
      add(1, 0, 0, 0, 0, 0,  5,  0, 0, 0, 0, 0, 0, 1, 4);

      repeat (3) @(negedge clk);
      chk("reset stage",    32'(bus.stage), 0);
      chk("reset imem_req", 32'(bus.imem_req), 1);
      chk("reset dmem_req", 32'(bus.dmem_req), 0);
      chk("reset pc_we",    32'(bus.pc_we), 0);
      chk("reset halted",   32'(bus.halted), 0);
      chk("reset retired",  bus.retired, 0);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].ia, vq[i].da, vq[i].ld, vq[i].st, vq[i].ht, vq[i].rw);
         #1;
         chk($sformatf("row%0d stage", i),    32'(bus.stage),    32'(vq[i].stg));
         chk($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(vq[i].ireq));
         chk($sformatf("row%0d ir_we", i),    32'(bus.ir_we),    32'(vq[i].irwe));
         chk($sformatf("row%0d dmem_req", i), 32'(bus.dmem_req), 32'(vq[i].dreq));
         chk($sformatf("row%0d dmem_we", i),  32'(bus.dmem_we),  32'(vq[i].dwe));
         chk($sformatf("row%0d rf_we", i),    32'(bus.rf_we),    32'(vq[i].rfwe));
         chk($sformatf("row%0d pc_we", i),    32'(bus.pc_we),    32'(vq[i].pcwe));
         chk($sformatf("row%0d halted", i),   32'(bus.halted),   32'(vq[i].hlt));
         chk($sformatf("row%0d retired", i),  bus.retired,       32'(vq[i].ret));
         @(negedge clk);
      end

      // Halt is sticky regardless of acks and flags.
      for (int c = 0; c < 20; c++) begin
         drive(1, 1, 1, 0, 0, 1);
         #1;
         chk($sformatf("halt%0d stage", c),   32'(bus.stage), 5);
         chk($sformatf("halt%0d halted", c),  32'(bus.halted), 1);
         chk($sformatf("halt%0d strobes", c),
             32'({bus.imem_req, bus.ir_we, bus.pc_we, bus.rf_we, bus.dmem_req}), 0);
         chk($sformatf("halt%0d retired", c), bus.retired, 4);
         @(negedge clk);
      end
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("unhalt stage",  32'(bus.stage), 0);
      chk("unhalt halted", 32'(bus.halted), 0);
      chk("unhalt imem_req", 32'(bus.imem_req), 1);
      @(negedge clk);
      rst = 1'b0;

      // Reset while a load waits in MEM.
      drive(1, 0, 0, 0, 0, 1);
      @(negedge clk);
      drive(0, 0, 1, 0, 0, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("midmem stage", 32'(bus.stage), 3);
      chk("midmem dmem_req", 32'(bus.dmem_req), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midmem rst dmem_req", 32'(bus.dmem_req), 0);
      chk("midmem rst stage",    32'(bus.stage), 0);
      chk("midmem rst retired",  bus.retired, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(0, 1, 0, 0, 0, 0);
         #1;
         chk($sformatf("stray%0d stage", c),    32'(bus.stage), 0);
         chk($sformatf("stray%0d imem_req", c), 32'(bus.imem_req), 1);
         chk($sformatf("stray%0d dmem_req", c), 32'(bus.dmem_req), 0);
         @(negedge clk);
      end

      // 4-bit counter wraps after 16 retirements.
      rst2 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         repeat (4) @(negedge clk);
         #1;
         chk($sformatf("wrap%0d stage", k),   32'(bus2.stage), 0);
         chk($sformatf("wrap%0d retired", k), 32'(bus2.retired), 32'(k % 16));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle sequencer for the dCPU core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the strobes that move data through the shared datapath: IR latch, register-file write, data-memory request and PC update. It consumes the instruction-class flags produced by the decoder and handshakes with instruction and data memory of variable latency. A halt instruction parks the core until reset.

## Interface
- `RESET_STAGE`, default 3'd0 (FETCH): state entered on reset. It is fixed at FETCH and exists for documentation only.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  instruction word valid this cycle.
- `ir_we`  out  1  latch the instruction word into IR.
- `is_load`  in  1  decoder flag, load instruction.
- `is_store`  in  1  decoder flag, store instruction.
- `is_halt`  in  1  decoder flag, halt instruction.
- `reg_we`  in  1  decoder flag, instruction writes rd.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  data-memory write (store); valid only while `dmem_req`=1.
- `dmem_ack`  in  1  data access complete; load data valid this cycle.
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  commit next-PC from the datapath.
- `stage`  out  3  current state encoding.
- `halted`  out  1  core is halted.
- `retired`  out  CNT_W  count of completed non-halt instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to FETCH on the next edge.
- **FETCH**
  - `imem_req`=1 is held until `imem_ack`.
  - On `imem_ack`, `ir_we`=1 in the same cycle (combinational: `imem_req & imem_ack`), then go to DECODE.
- **DECODE**
  - One cycle. Sample `is_load`, `is_store`, `is_halt` and `reg_we` into internal registers at the end of this cycle.
  - If `is_halt`=1, go to HALT; otherwise go to EXEC.
  - Later states use only the latched copies.
- **EXEC**
  - One cycle (ALU evaluation).
  - If the latched load or store flag is set, go to MEM; otherwise go to WB.
- **MEM**
  - `dmem_req`=1 and `dmem_we`=latched store flag, held until `dmem_ack`, then go to WB.
  - The request is level-held; the memory must not see a deassert before ack.
- **WB**
  - One cycle. `rf_we`=latched `reg_we`, `pc_we`=1, `retired` increments by 1, then go to FETCH.
  - A store with `reg_we`=0 produces `rf_we`=0.
- **HALT**
  - Sticky. `halted`=1; all strobes are 0.
  - Only `rst` exits HALT. `retired` does not count the halt instruction, and `pc_we` is not asserted.
- **Stray acks:** `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored and have no effect.
- **Illegal flag combination:** if `is_load` and `is_store` are both 1 at DECODE, treat the instruction as a load (`dmem_we`=0).
- **Counter:** `retired` wraps modulo 2^CNT_W with no saturation.
- **Output timing:** all strobes are decoded from the registered state plus latched flags; only `ir_we` also depends on `imem_ack`.

## Timing
- Reset values: `stage`=0 (FETCH), `retired`=0, `halted`=0, latched flags=0, `imem_req`=1, and all other strobes 0.
- Reset asynchronously forces FETCH mid-operation, including MEM with an access pending. `dmem_req` drops in the same instant with no completion.
- ALU/branch instruction with an ack in the first fetch cycle takes 4 cycles: FETCH, DECODE, EXEC, WB.
- Load/store with both acks immediate takes 5 cycles.
- Each cycle `imem_ack` or `dmem_ack` is withheld adds exactly one cycle.
- `pc_we` is asserted exactly once per non-halt instruction, in WB. `ir_we` is asserted exactly once per instruction.
- `imem_req` rises in the cycle after WB; there are no idle cycles between instructions.
- `halted` rises in the cycle after DECODE of the halt instruction.

## Test plan
- **Reset:** deassert `rst` with `imem_ack` tied 1 and all decoder flags 0. Expect `stage` sequence 0,1,2,4,0. `pc_we` and `rf_we` (with `reg_we`=1) pulse once in cycle 4. `retired`=1 after 4 cycles.
- **Load with waits:** fetch acks after 2 wait cycles; `is_load`=1, `reg_we`=1; `dmem_ack` after 3 wait cycles. Expect `dmem_req` high for 4 cycles with `dmem_we`=0. Total 10 cycles; one `rf_we` pulse.
- **Store:** `is_store`=1, `reg_we`=0, `dmem_ack` immediate. Expect `dmem_we`=1 during MEM, `rf_we`=0 in WB, `pc_we`=1, `retired` +1.
- **Halt:** `is_halt`=1 at DECODE. Expect `stage`=5 and `halted`=1 for 20 further cycles. `imem_req`, `pc_we` and `rf_we` stay 0; `retired` unchanged. A later `rst` pulse returns `stage`=0 and `halted`=0.
- **Reset mid-MEM:** assert `rst` during MEM while `dmem_ack`=0. Expect `dmem_req`=0 immediately, `stage`=0 and `retired`=0. Then drive a spurious `dmem_ack` in FETCH and expect no state change.
- **Counter wrap:** with `CNT_W`=4, run 17 ALU instructions. Expect `retired` 15 then 0, then 1.
